if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipelined MIPS core. Holds the PC, drives the instruction-memory address, and registers the fetched instruction, PC and PC+4 into ID. The ID stage splits off the 16-bit immediate for sign extension. Supports load-use stalls from the hazard unit and one-cycle branch/jump redirects resolved in ID, and keeps saturating stall/flush event counters for debug.

## Interface
- PC_WIDTH, 32, PC and address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_WIDTH, 16, width of debug event counters
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID contents this cycle
- redirect_valid  in  1  ID resolved a taken branch/jump this cycle
- redirect_pc  in  PC_WIDTH  target address; bits [1:0] ignored
- imem_addr  out  PC_WIDTH  instruction-memory address (= current PC, combinational from PC register)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- id_instr  out  32  registered instruction for ID
- id_imm  out  16  id_instr[15:0], feeds the sign extender
- id_pc  out  PC_WIDTH  address of id_instr
- id_pc_plus4  out  PC_WIDTH  id_pc + 4
- id_valid  out  1  0 when IF/ID holds a bubble
- stall_cnt  out  CNT_WIDTH  cycles with stall accepted, saturating
- flush_cnt  out  CNT_WIDTH  redirects accepted, saturating

## Operation
- Per-edge priority: reset > redirect_valid > stall > normal advance.
- Reset: pc <= RESET_PC; id_instr <= 32'h0000_0000 (NOP); id_pc <= 0; id_pc_plus4 <= 0; id_valid <= 0; stall_cnt <= 0; flush_cnt <= 0.
- Normal (no stall, no redirect): pc <= pc + 4; id_instr <= imem_rdata; id_pc <= pc; id_pc_plus4 <= pc + 4; id_valid <= 1.
- Stall (no redirect): pc and all id_* hold; stall_cnt increments.
- Redirect: pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}; IF/ID flushed to bubble (id_instr = NOP, id_valid = 0, id_pc = id_pc_plus4 = 0); flush_cnt increments; stall ignored that cycle and stall_cnt does not increment.
- PC arithmetic modulo 2^PC_WIDTH: pc = 32'hFFFF_FFFC advances to 32'h0000_0000, no flag.
- pc[1:0] is always 00.
- Counters saturate at all-ones and hold; cleared only by reset.
- id_imm is a pure slice of id_instr, so it is 16'h0000 during bubbles and after reset.

## Timing
- Fetch-to-ID latency: 1 cycle; instruction at PC visible on id_instr the cycle after pc = that address without stall.
- Branch penalty: 1 bubble. Redirect in cycle N gives pc = target and bubble in ID at N+1, and the target instruction in ID at N+2.
- Stall held k cycles: id_* frozen k cycles; fetch resumes on the first cycle stall is low.
- Reset asserted mid-stream overrides everything on that edge; first valid instruction (from RESET_PC) appears in ID 1 cycle after reset deasserts.
- imem_addr changes only on clock edges; no combinational path from stall/redirect inputs to imem_addr.

## Structure
- Shared package/header: NOP encoding (32'h0), PC step (4), default RESET_PC. Decode/ID stages use the same NOP definition for their bubbles.
- One sub-module: pc_reg (PC register with reset, load-target, hold and increment; priority as above). The IF/ID register and counters live in if_id_stage.

## Test plan
- Reset then free-run with imem returning addr-based words (e.g. instr = addr ^ 32'hA5A5_0000): after reset release, id_pc follows 0, 4, 8… one per cycle, and id_instr matches the word for id_pc. id_valid goes 1 one cycle after release.
- Stall for 3 cycles while pc = 0x10: imem_addr stays 0x10 and id_pc stays 0x0C for 3 cycles; stall_cnt = 3. The next cycle gives id_pc = 0x10.
- Redirect to 0x0000_0203 while pc = 0x20: next cycle pc = 0x200, id_valid = 0, id_instr = 0, flush_cnt = 1. Cycle after that, id_pc = 0x200 with id_valid = 1.
- Redirect and stall asserted together: redirect taken, bubble inserted, stall_cnt unchanged, flush_cnt increments.
- PC wrap with RESET_PC = 32'hFFFF_FFF8: id_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Counter saturation with CNT_WIDTH = 4: hold stall 20 cycles, so stall_cnt reaches 4'hF and stays. Reset mid-stall clears all outputs to their reset values on that edge.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_pkg
// Description : Constants shared by the fetch stage and the decode-side
//               pipeline registers (bubble encoding, PC step, reset PC).
// Revision    : 1.0  initial release
// ============================================================================
package if_id_stage_pkg;

  // All-zero word is sll $0,$0,0 -- every bubble in the pipe uses this.
  localparam logic [31:0] c_nop              = 32'h0000_0000;
  localparam int unsigned c_pc_step          = 4;
  localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;

endpackage : if_id_stage_pkg
`default_nettype wire

// File: rtl/if_id_stage_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_pc_reg
// Description : Program counter with synchronous reset, redirect load,
//               hold and +4 advance. Priority: reset > load > hold > advance.
// Ports       : clk, reset      - clock / sync active-high reset
//               i_load, i_target - redirect request and target (bits [1:0] dropped)
//               i_hold           - freeze PC this cycle
//               o_pc             - current PC (word aligned)
//               o_pc_plus4       - o_pc + 4, wraps modulo 2^PC_WIDTH
// Revision    : 1.0  initial release
// ============================================================================
module if_id_stage_pc_reg
  import if_id_stage_pkg::*;
#(
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(c_reset_pc_default)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [PC_WIDTH-1:0] i_target,
  input  logic                i_hold,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [PC_WIDTH-1:0] o_pc_plus4
);

  // Low bits forced to zero so the PC can never become misaligned.
  localparam logic [PC_WIDTH-1:0] c_reset_pc_aligned = {RESET_PC[PC_WIDTH-1:2], 2'b00};

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic                w_unused_target_lsbs;

  assign w_pc_plus4           = r_pc + PC_WIDTH'(c_pc_step);
  assign w_unused_target_lsbs = ^i_target[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= c_reset_pc_aligned;
    end else if (i_load) begin
      r_pc <= {i_target[PC_WIDTH-1:2], 2'b00};
    end else if (!i_hold) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule : if_id_stage_pc_reg
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : Instruction fetch plus IF/ID pipeline register. Drives the
//               instruction-memory address from the PC, registers the fetched
//               word with its PC and PC+4, and counts stall/flush events.
// Ports       : clk, reset        - clock / sync active-high reset
//               stall             - hold PC and IF/ID this cycle
//               redirect_valid/pc - taken branch/jump from ID (wins over stall)
//               imem_addr/rdata   - instruction memory (combinational read)
//               id_instr/imm/pc/pc_plus4/valid - IF/ID contents for ID
//               stall_cnt/flush_cnt - saturating debug event counters
// Revision    : 1.0  initial release
// ============================================================================
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int                    PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = PC_WIDTH'(c_reset_pc_default),
  parameter int                    CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          id_instr,
  output logic [15:0]          id_imm,
  output logic [PC_WIDTH-1:0]  id_pc,
  output logic [PC_WIDTH-1:0]  id_pc_plus4,
  output logic                 id_valid,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  logic [PC_WIDTH-1:0]  w_pc;
  logic [PC_WIDTH-1:0]  w_pc_plus4;
  logic [31:0]          r_id_instr;
  logic [PC_WIDTH-1:0]  r_id_pc;
  logic [PC_WIDTH-1:0]  r_id_pc_plus4;
  logic                 r_id_valid;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  if_id_stage_pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (redirect_valid),
    .i_target   (redirect_pc),
    .i_hold     (stall),
    .o_pc       (w_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  // Address comes straight from the PC flop: no path from stall/redirect.
  assign imem_addr = w_pc;

  // IF/ID register. A redirect squashes the wrong-path fetch even when the
  // hazard unit is also stalling, since the stalled instruction is now dead.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      r_id_instr    <= c_nop;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_id_valid    <= 1'b0;
    end else if (!stall) begin
      r_id_instr    <= imem_rdata;
      r_id_pc       <= w_pc;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
    end
  end

  // Debug counters: a stall overridden by a redirect is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (redirect_valid) begin
      if (r_flush_cnt != c_cnt_max) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end else if (stall) begin
      if (r_stall_cnt != c_cnt_max) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign id_instr    = r_id_instr;
  assign id_imm      = r_id_instr[15:0];
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_valid    = r_id_valid;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule : if_id_stage
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Scoreboard bench for if_id_stage. Two instances share inputs:
//               A (RESET_PC=0, 4-bit counters) and B (RESET_PC=FFFF_FFF8,
//               16-bit counters). Expected IF/ID state is pushed when a cycle
//               is driven and compared after the clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_stage;

  localparam logic [31:0] c_mask = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;

  // Instance A outputs
  logic [31:0] imem_addr_a, imem_rdata_a, id_instr_a, id_pc_a, id_pc4_a;
  logic [15:0] id_imm_a;
  logic        id_valid_a;
  logic [3:0]  scnt_a, fcnt_a;
  // Instance B outputs
  logic [31:0] imem_addr_b, imem_rdata_b, id_instr_b, id_pc_b, id_pc4_b;
  logic [15:0] id_imm_b;
  logic        id_valid_b;
  logic [15:0] scnt_b, fcnt_b;

  assign imem_rdata_a = imem_addr_a ^ c_mask;
  assign imem_rdata_b = imem_addr_b ^ c_mask;

  always #5 clk = ~clk;

  if_id_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
    .id_instr(id_instr_a), .id_imm(id_imm_a), .id_pc(id_pc_a), .id_pc_plus4(id_pc4_a),
    .id_valid(id_valid_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
  );

  if_id_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .id_instr(id_instr_b), .id_imm(id_imm_b), .id_pc(id_pc_b), .id_pc_plus4(id_pc4_b),
    .id_valid(id_valid_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
  );

  typedef struct packed {
    logic [31:0] pc, instr, idpc, idpc4;
    logic        valid;
    logic [15:0] scnt, fcnt;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } exp_pair_t;

  exp_pair_t sb_q[$];
  exp_t      m_a, m_b;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference behaviour of one instance for one clock edge.
  function automatic exp_t model(input exp_t m, input logic [31:0] rst_pc,
                                 input logic [15:0] cmax, input logic r,
                                 input logic s, input logic rv, input logic [31:0] rp);
    exp_t n = m;
    if (r) begin
      n = '0;
      n.pc = rst_pc;
    end else if (rv) begin
      n.pc    = {rp[31:2], 2'b00};
      n.instr = 32'h0;
      n.idpc  = 32'h0;
      n.idpc4 = 32'h0;
      n.valid = 1'b0;
      if (m.fcnt != cmax) n.fcnt = m.fcnt + 16'd1;
    end else if (s) begin
      if (m.scnt != cmax) n.scnt = m.scnt + 16'd1;
    end else begin
      n.instr = m.pc ^ c_mask;
      n.idpc  = m.pc;
      n.idpc4 = m.pc + 32'd4;
      n.valid = 1'b1;
      n.pc    = m.pc + 32'd4;
    end
    return n;
  endfunction

  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    exp_pair_t e;
    @(negedge clk);
    reset = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    #1;
    // Changing stall/redirect must not move the fetch address before the edge.
    chk("a_imem_addr_pre", imem_addr_a, m_a.pc);
    m_a = model(m_a, 32'h0000_0000, 16'h000F, r, s, rv, rp);
    m_b = model(m_b, 32'hFFFF_FFF8, 16'hFFFF, r, s, rv, rp);
    e.a = m_a;
    e.b = m_b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("a_imem_addr", imem_addr_a, e.a.pc);
    chk("a_id_instr",  id_instr_a,  e.a.instr);
    chk("a_id_imm",    {16'h0, id_imm_a}, {16'h0, e.a.instr[15:0]});
    chk("a_id_pc",     id_pc_a,     e.a.idpc);
    chk("a_id_pc4",    id_pc4_a,    e.a.idpc4);
    chk("a_id_valid",  {31'h0, id_valid_a}, {31'h0, e.a.valid});
    chk("a_stall_cnt", {28'h0, scnt_a}, {16'h0, e.a.scnt});
    chk("a_flush_cnt", {28'h0, fcnt_a}, {16'h0, e.a.fcnt});
    chk("b_imem_addr", imem_addr_b, e.b.pc);
    chk("b_id_instr",  id_instr_b,  e.b.instr);
    chk("b_id_imm",    {16'h0, id_imm_b}, {16'h0, e.b.instr[15:0]});
    chk("b_id_pc",     id_pc_b,     e.b.idpc);
    chk("b_id_pc4",    id_pc4_b,    e.b.idpc4);
    chk("b_id_valid",  {31'h0, id_valid_b}, {31'h0, e.b.valid});
    chk("b_stall_cnt", {16'h0, scnt_b}, {16'h0, e.b.scnt});
    chk("b_flush_cnt", {16'h0, fcnt_b}, {16'h0, e.b.fcnt});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    m_a = '0;
    m_b = '0;
    // Bring both instances out of X before the scoreboard takes over.
    repeat (2) @(posedge clk);
    m_b.pc = 32'hFFFF_FFF8;

    step(1'b1, 1'b0, 1'b0, 32'h0);                 // reset state
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);      // pc -> 0x10; B wraps past 0
    chk("a_pc_at_0x10", imem_addr_a, 32'h0000_0010);
    chk("b_wrapped_id_pc", id_pc_b, 32'h0000_0004);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);      // 3-cycle stall
    chk("a_stall_cnt_3", {28'h0, scnt_a}, 32'd3);
    step(1'b0, 1'b0, 1'b0, 32'h0);                 // id_pc = 0x10
    chk("a_resume_id_pc", id_pc_a, 32'h0000_0010);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);      // pc -> 0x20
    step(1'b0, 1'b0, 1'b1, 32'h0000_0203);         // redirect, misaligned target
    chk("a_redirect_pc", imem_addr_a, 32'h0000_0200);
    step(1'b0, 1'b0, 1'b0, 32'h0);                 // target in ID, valid
    chk("a_target_in_id", id_pc_a, 32'h0000_0200);
    step(1'b0, 1'b1, 1'b1, 32'h0000_1000);         // redirect + stall together
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin             // saturate 4-bit stall counter
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
    chk("a_stall_sat", {28'h0, scnt_a}, 32'h0000_000F);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3FFF);         // redirect with both LSBs set
    step(1'b1, 1'b1, 1'b0, 32'h0);                 // reset mid-stall
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin             // saturate 4-bit flush counter
      step(1'b0, 1'b0, 1'b1, 32'h0000_0100 + 32'(i * 8));
    end
    chk("a_flush_sat", {28'h0, fcnt_a}, 32'h0000_000F);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_if_id_stage
`default_nettype wire
